// File: rtl/char_seq_pkg.sv
// Shared types and default parameters for the character step sequencer.
package char_seq_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } seq_state_t;

  localparam int DEFAULT_BASE_SHIFT = 16;
  localparam int DEFAULT_DB_W       = 10;

endpackage

// File: rtl/btn_debounce.sv
// Step button conditioning: 2-flop synchronizer, stability counter and
// rising-edge detect producing a single-cycle press strobe.
module btn_debounce
  import char_seq_pkg::*;
#(
  parameter int DB_W = DEFAULT_DB_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_raw,
  output logic press
);

  logic [1:0]      btn_sync;
  logic            btn_s;
  logic            level;
  logic [DB_W-1:0] stable_cnt;

  assign btn_s = btn_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= 2'b00;
    end else begin
      btn_sync <= {btn_sync[0], btn_raw};
    end
  end

  // stable_cnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (ena) begin
      if (btn_s == level) begin
        stable_cnt <= '0;
      end else if (&stable_cnt) begin
        stable_cnt <= '0;
        level      <= btn_s;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign press = ena & btn_s & ~level & (&stable_cnt);

endmodule

// File: rtl/char_step_sequencer.sv
// Glyph index sequencer: free-running stepping at a programmable rate, or
// manual stepping from a debounced push-button, up or down with wrap.
module char_step_sequencer
  import char_seq_pkg::*;
#(
  parameter int BASE_SHIFT = DEFAULT_BASE_SHIFT,
  parameter int DB_W       = DEFAULT_DB_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       run,
  input  logic       dir,
  input  logic       step_btn,
  input  logic [2:0] rate,
  input  logic [3:0] last_idx,
  output logic [3:0] idx,
  output logic       advance,
  output logic       wrap,
  output logic       at_last
);

  localparam int PRE_W = BASE_SHIFT + 7;

  logic [1:0]       run_sync;
  logic [1:0]       dir_sync;
  logic             run_s;
  logic             dir_s;
  logic             press;
  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] tick_mask;
  logic             tick;
  logic             step_en;
  logic [3:0]       idx_nxt;
  logic             wrap_nxt;
  logic             adv_q;
  logic             wrap_q;

  assign run_s = run_sync[1];
  assign dir_s = dir_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_sync <= 2'b00;
      dir_sync <= 2'b00;
    end else begin
      run_sync <= {run_sync[0], run};
      dir_sync <= {dir_sync[0], dir};
    end
  end

  btn_debounce #(.DB_W(DB_W)) u_btn_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .btn_raw (step_btn),
    .press   (press)
  );

  // Mask is recomputed every cycle so a rate change applies to the current period
  always_comb begin
    tick_mask = ~({PRE_W{1'b1}} << (BASE_SHIFT + int'(rate)));
    tick      = (state == RUNNING) && ((pre & tick_mask) == tick_mask);
  end

  always_comb begin
    state_nxt = state;
    step_en   = 1'b0;
    case (state)
      STOPPED: begin
        step_en = press;
        if (run_s) state_nxt = RUNNING;
      end
      RUNNING: begin
        step_en = tick & run_s;
        if (!run_s) state_nxt = STOPPED;
      end
      default: state_nxt = STOPPED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STOPPED;
      pre   <= '0;
    end else if (ena) begin
      state <= state_nxt;
      if (state == STOPPED && state_nxt == RUNNING) begin
        pre <= '0;
      end else if (state == RUNNING) begin
        pre <= pre + 1'b1;
      end
    end
  end

  // An idx beyond last_idx (after last_idx was lowered) wraps on its next step
  always_comb begin
    idx_nxt  = idx;
    wrap_nxt = 1'b0;
    if (!dir_s) begin
      if (idx >= last_idx) begin
        idx_nxt  = 4'd0;
        wrap_nxt = 1'b1;
      end else begin
        idx_nxt = idx + 4'd1;
      end
    end else begin
      if (idx == 4'd0 || idx > last_idx) begin
        idx_nxt  = last_idx;
        wrap_nxt = 1'b1;
      end else begin
        idx_nxt = idx - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= 4'd0;
      adv_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      adv_q  <= ena & step_en;
      wrap_q <= ena & step_en & wrap_nxt;
      if (ena && step_en) idx <= idx_nxt;
    end
  end

  assign advance = adv_q & ena;
  assign wrap    = wrap_q & ena;
  assign at_last = (idx == last_idx);

endmodule

// File: tb/tb_char_step_sequencer.sv
// Self-checking bench for char_step_sequencer with BASE_SHIFT=2, DB_W=3.
module tb_char_step_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       run = 1'b0;
  logic       dir = 1'b0;
  logic       step_btn = 1'b0;
  logic [2:0] rate = 3'd0;
  logic [3:0] last_idx = 4'd15;
  logic [3:0] idx;
  logic       advance;
  logic       wrap;
  logic       at_last;

  int checks = 0;
  int errors = 0;
  int adv_count = 0;

  char_step_sequencer #(.BASE_SHIFT(2), .DB_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .run      (run),
    .dir      (dir),
    .step_btn (step_btn),
    .rate     (rate),
    .last_idx (last_idx),
    .idx      (idx),
    .advance  (advance),
    .wrap     (wrap),
    .at_last  (at_last)
  );

  always #5 clk = ~clk;

  // Behavioural model: synchronizer delays as two-deep histories, the step
  // period as "enabled running cycles modulo 2^(2+rate)", and the debounce as
  // a run length of identical synchronized button samples.
  bit       m_run_p, m_run_s, m_dir_p, m_dir_s, m_btn_p, m_btn_s;
  bit       m_running;
  int       m_phase;
  bit       m_lvl;
  bit       m_last_smp;
  int       m_runlen;
  logic [3:0] m_idx = 4'd0;
  bit       m_adv, m_wrap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run_p = 0; m_run_s = 0; m_dir_p = 0; m_dir_s = 0; m_btn_p = 0; m_btn_s = 0;
      m_running = 0; m_phase = 0; m_lvl = 0; m_last_smp = 0; m_runlen = 0;
      m_idx = 4'd0; m_adv = 0; m_wrap = 0;
    end else begin
      int  period;
      bit  tick, press, adv;
      m_adv  = 0;
      m_wrap = 0;
      if (ena) begin
        press = 0;
        if (m_btn_s == m_last_smp) begin
          if (m_runlen < 1000) m_runlen++;
        end else begin
          m_runlen = 1;
        end
        m_last_smp = m_btn_s;
        if (m_btn_s != m_lvl && m_runlen >= 8) begin
          press = m_btn_s;
          m_lvl = m_btn_s;
        end
        period = 1 << (2 + int'(rate));
        tick   = m_running && ((m_phase % period) == period - 1);
        adv    = m_running ? (tick && m_run_s) : press;
        if (adv) begin
          m_adv = 1;
          if (!m_dir_s) begin
            if (m_idx >= last_idx) begin m_idx = 4'd0; m_wrap = 1; end
            else m_idx = m_idx + 4'd1;
          end else begin
            if (m_idx == 4'd0 || m_idx > last_idx) begin m_idx = last_idx; m_wrap = 1; end
            else m_idx = m_idx - 4'd1;
          end
        end
        if (!m_running && m_run_s) begin
          m_running = 1;
          m_phase   = 0;
        end else if (m_running) begin
          m_phase++;
          if (!m_run_s) m_running = 0;
        end
      end
      m_run_s = m_run_p; m_run_p = run;
      m_dir_s = m_dir_p; m_dir_p = dir;
      m_btn_s = m_btn_p; m_btn_p = step_btn;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    checks++;
    if (idx !== m_idx || advance !== (m_adv & ena) || wrap !== (m_wrap & ena) ||
        at_last !== (m_idx == last_idx)) begin
      errors++;
      $display("[TB] FAIL model_cycle t=%0t got idx=%0d adv=%b wrap=%b at_last=%b need idx=%0d adv=%b wrap=%b at_last=%b",
               $time, idx, advance, wrap, at_last, m_idx, m_adv & ena, m_wrap & ena, (m_idx == last_idx));
    end
    if (advance === 1'b1) adv_count++;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic d, input logic [2:0] rt, input logic [3:0] li);
    run      = r;
    dir      = d;
    rate     = rt;
    last_idx = li;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_idx, input logic e_adv, input logic e_wrap);
    checks++;
    if (idx !== e_idx || advance !== e_adv || wrap !== e_wrap) begin
      errors++;
      $display("[TB] FAIL %s got idx=%0d adv=%b wrap=%b need idx=%0d adv=%b wrap=%b",
               name, idx, advance, wrap, e_idx, e_adv, e_wrap);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int need);
    checks++;
    if (got != need) begin
      errors++;
      $display("[TB] FAIL %s got %0d need %0d", name, got, need);
    end
  endtask

  task automatic doReset(input string name);
    rst_n = 1'b0;
    #1;
    checkOutput(name, 4'd0, 1'b0, 1'b0);
    waitCycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    #2;
    doReset("reset_initial");

    $display("[TB] up count, rate 0, last 15");
    applyStimulus(1'b1, 1'b0, 3'd0, 4'd15);
    waitCycles(6);  checkOutput("up_before_first", 4'd0, 1'b0, 1'b0);
    waitCycles(1);  checkOutput("up_first_adv", 4'd1, 1'b1, 1'b0);
    waitCycles(56); checkOutput("up_reach_15", 4'd15, 1'b1, 1'b0);
    waitCycles(4);  checkOutput("up_wrap_0", 4'd0, 1'b1, 1'b1);
    waitCycles(1);  checkOutput("up_pulse_end", 4'd0, 1'b0, 1'b0);

    $display("[TB] down count, rate 1, last 5");
    doReset("reset_b");
    applyStimulus(1'b1, 1'b1, 3'd1, 4'd5);
    waitCycles(11); checkOutput("down_first_wrap", 4'd5, 1'b1, 1'b1);
    waitCycles(8);  checkOutput("down_to_4", 4'd4, 1'b1, 1'b0);
    waitCycles(32); checkOutput("down_to_0", 4'd0, 1'b1, 1'b0);
    waitCycles(8);  checkOutput("down_wrap_5", 4'd5, 1'b1, 1'b1);

    $display("[TB] manual step with bouncing button");
    doReset("reset_c");
    applyStimulus(1'b0, 1'b0, 3'd0, 4'd15);
    base = adv_count;
    for (int i = 0; i < 5; i++) begin
      step_btn = (i % 2 == 0);
      waitCycles(1);
    end
    step_btn = 1'b1;
    waitCycles(20);
    checkOutput("press_stopped", 4'd1, 1'b0, 1'b0);
    checkCount("press_adv_count", adv_count - base, 1);
    step_btn = 1'b0;
    waitCycles(20);
    applyStimulus(1'b1, 1'b0, 3'd7, 4'd15);
    waitCycles(5);
    base = adv_count;
    step_btn = 1'b1;
    waitCycles(20);
    checkOutput("press_running_ignored", 4'd1, 1'b0, 1'b0);
    checkCount("press_running_count", adv_count - base, 0);
    step_btn = 1'b0;

    $display("[TB] last_idx lowered below idx");
    doReset("reset_d");
    applyStimulus(1'b1, 1'b0, 3'd0, 4'd15);
    waitCycles(51); checkOutput("shrink_at_12", 4'd12, 1'b1, 1'b0);
    last_idx = 4'd7;
    waitCycles(3);  checkOutput("shrink_hold_12", 4'd12, 1'b0, 1'b0);
    waitCycles(1);  checkOutput("shrink_wrap", 4'd0, 1'b1, 1'b1);

    $display("[TB] enable freeze");
    doReset("reset_e");
    applyStimulus(1'b1, 1'b0, 3'd0, 4'd15);
    waitCycles(15); checkOutput("ena_pre_3", 4'd3, 1'b1, 1'b0);
    waitCycles(2);
    ena = 1'b0;
    base = adv_count;
    waitCycles(50); checkOutput("ena_frozen", 4'd3, 1'b0, 1'b0);
    checkCount("ena_frozen_count", adv_count - base, 0);
    ena = 1'b1;
    waitCycles(1);  checkOutput("ena_resume_hold", 4'd3, 1'b0, 1'b0);
    waitCycles(1);  checkOutput("ena_resume_tick", 4'd4, 1'b1, 1'b0);
    waitCycles(4);  checkOutput("ena_resume_next", 4'd5, 1'b1, 1'b0);

    $display("[TB] reset mid-sequence");
    doReset("reset_f");
    applyStimulus(1'b1, 1'b0, 3'd0, 4'd15);
    waitCycles(41); checkOutput("midrst_at_9", 4'd9, 1'b0, 1'b0);
    doReset("midrst_async");
    waitCycles(6);  checkOutput("midrst_no_adv", 4'd0, 1'b0, 1'b0);
    waitCycles(1);  checkOutput("midrst_first_adv", 4'd1, 1'b1, 1'b0);

    waitCycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_step_sequencer.md
CHAR_STEP_SEQUENCER -- requirements
Module: char_step_sequencer

Interface
REQ-001 Parameter BASE_SHIFT, default 16: run-mode step period is 2^(BASE_SHIFT+rate) clk cycles.
REQ-002 Parameter DB_W, default 10: step button must be stable for 2^DB_W clk cycles to be accepted.
REQ-003 clk  in  1  single design clock; all flops on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ena  in  1  global enable; low freezes all state except synchronizers.
REQ-006 run  in  1  async level; 1 = auto-advance, 0 = stopped/manual.
REQ-007 dir  in  1  async level; 0 = count up, 1 = count down.
REQ-008 step_btn  in  1  async raw push-button, active-high, bouncy.
REQ-009 rate  in  3  step-rate select, 0 (fastest) to 7 (slowest), sampled every cycle.
REQ-010 last_idx  in  4  final index of sequence, 0-15; sequence length = last_idx+1.
REQ-011 idx  out  4  registered glyph index for the downstream glyph-decode mux tree.
REQ-012 advance  out  1  registered one-cycle pulse in the cycle idx takes a new value.
REQ-013 wrap  out  1  registered one-cycle pulse when an advance wraps the sequence.
REQ-014 at_last  out  1  combinational: idx == last_idx.

Function
REQ-015 run, dir and step_btn SHALL each pass through a 2-flop synchronizer before any use.
REQ-016 The synchronized step_btn SHALL be debounced: output changes only after 2^DB_W consecutive equal samples; a press event is the debounced 0->1 edge.
REQ-017 FSM states SHALL be STOPPED, RUNNING; STOPPED->RUNNING when synced run=1, RUNNING->STOPPED when synced run=0.
REQ-018 Prescaler SHALL be BASE_SHIFT+7 bits, cleared on STOPPED->RUNNING transition, incrementing every enabled cycle in RUNNING.
REQ-019 In RUNNING a tick SHALL occur when prescaler bits [BASE_SHIFT+rate-1:0] are all ones; a rate change mid-period takes effect at once, no extra tick.
REQ-020 Advance SHALL occur on a tick in RUNNING, or on a press event in STOPPED; press events in RUNNING SHALL be discarded.
REQ-021 Up advance: idx>=last_idx -> 0 with wrap=1, else idx+1.
REQ-022 Down advance: idx==0 or idx>last_idx -> last_idx with wrap=1, else idx-1.
REQ-023 Synced run falling in the same cycle as a tick SHALL suppress that advance.
REQ-024 dir SHALL be sampled (synced value) in the advance cycle only; changes between advances have no effect.
REQ-025 Lowering last_idx below idx SHALL NOT move idx until the next advance (REQ-021/022 rules apply).
REQ-026 advance and wrap SHALL be 0 in every cycle without an advance; idx update latency = 1 clk after tick/press detection.
REQ-027 ena=0 SHALL hold FSM, prescaler, debounce counter, idx; advance and wrap SHALL read 0 while ena=0.

Reset
REQ-028 rst_n low SHALL asynchronously force idx=0, advance=0, wrap=0, FSM=STOPPED, prescaler=0, debounce counter=0, debounced level=0, synchronizer flops=0.
REQ-029 Reset mid-sequence SHALL abandon the current step; after release the first advance SHALL produce idx=1 (up) or last_idx (down).
REQ-030 Release of rst_n SHALL NOT itself create a press event or advance.

Structure
REQ-031 Shared package char_seq_pkg SHALL hold the FSM state enum and default BASE_SHIFT/DB_W constants.
REQ-032 Debounce logic SHALL be one sub-module, btn_debounce (sync + counter + edge detect), instantiated once.

Verification (BASE_SHIFT=2, DB_W=3)
REQ-033 run=1, dir=0, rate=0, last_idx=15 -> advance every 4 clks, idx 0..15,0; wrap=1 exactly on 15->0.
REQ-034 run=1, dir=1, last_idx=5, rate=1 -> advance every 8 clks, idx 0->5->4..0->5; wrap on each 0->5.
REQ-035 run=0, step_btn bouncing 5 cycles then held high 20 cycles -> exactly one advance, idx 0->1; press during run=1 -> no advance.
REQ-036 idx=12 running up, last_idx changed to 7 -> idx holds 12 until next tick, then 0 with wrap=1.
REQ-037 ena=0 for 50 clks while running -> idx, prescaler frozen, advance=0; resume continues tick phase exactly.
REQ-038 rst_n asserted at idx=9 mid-period -> idx=0, outputs 0 immediately; after release, run=1, rate=0 -> first advance 4 clks after RUNNING entry.
